// File: rtl/gf_pkg.sv
// Shared GF(2^n) helpers for the GF-based ISE datapath: reduction polynomials,
// the serial-multiplier state encoding and a width/polynomial-parametrised xtime.
package gf_pkg;

  localparam logic [7:0] AES_POLY  = 8'h1B;
  localparam logic [3:0] GF16_POLY = 4'h3;

  // Widest field element the shared xtime helper can handle.
  localparam int GF_MAX_W = 32;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } gf_state_e;

  // Multiply by x in GF(2^width): shift left, fold the carried-out x^width term
  // back in through the low bits of the reduction polynomial.
  function automatic logic [GF_MAX_W-1:0] xtime(
    input logic [GF_MAX_W-1:0] a,
    input int unsigned         width,
    input logic [GF_MAX_W-1:0] poly
  );
    logic [GF_MAX_W-1:0] mask;
    logic [GF_MAX_W-1:0] sh;
    mask = (width >= GF_MAX_W) ? '1 : ((GF_MAX_W'(1) << width) - GF_MAX_W'(1));
    sh   = (a << 1) & mask;
    return a[width-1] ? (sh ^ (poly & mask)) : sh;
  endfunction

endpackage

// File: rtl/gf_xtime.sv
// Combinational WIDTH-bit multiply-by-x with reduction by POLY (x^WIDTH implicit).
module gf_xtime
  import gf_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(AES_POLY)
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] y
);

  logic [GF_MAX_W-1:0] y_full;

  assign y_full = xtime(GF_MAX_W'(a), WIDTH, GF_MAX_W'(POLY));
  assign y      = y_full[WIDTH-1:0];

endmodule

// File: rtl/gf_serial_mult.sv
// Constant-time serial GF(2^WIDTH) multiplier, one coefficient bit per cycle, LSB first.
// Optional accumulate mode (extra acc input) enabled by defining GF_SERIAL_MULT_ACC_EN.
module gf_serial_mult
  import gf_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter int               COEFF_W = 4,
  parameter logic [WIDTH-1:0] POLY    = WIDTH'(AES_POLY)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   in,
  input  logic [COEFF_W-1:0] coeff,
`ifdef GF_SERIAL_MULT_ACC_EN
  input  logic               acc,
`endif
  output logic               busy,
  output logic [WIDTH-1:0]   result,
  output logic               done
);

  localparam int CNT_W = (COEFF_W > 1) ? $clog2(COEFF_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COEFF_W - 1);

  gf_state_e          state;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   mult;
  logic [WIDTH-1:0]   mult_x;
  logic [COEFF_W-1:0] coeff_q;
  logic               clear_on_accept;

`ifdef GF_SERIAL_MULT_ACC_EN
  assign clear_on_accept = ~acc;
`else
  assign clear_on_accept = 1'b1;
`endif

  gf_xtime #(
    .WIDTH (WIDTH),
    .POLY  (POLY)
  ) u_xtime (
    .a (mult),
    .y (mult_x)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      mult    <= '0;
      coeff_q <= '0;
      result  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mult    <= in;
            coeff_q <= coeff;
            cnt     <= '0;
            if (clear_on_accept) begin
              result <= '0;
            end
            busy    <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          // Every coefficient bit costs one cycle whether it is set or not.
          if (coeff_q[cnt]) begin
            result <= result ^ mult;
          end
          mult <= mult_x;
          cnt  <= cnt + CNT_W'(1);
          if (cnt == CNT_LAST) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gf_serial_mult.sv
// Directed self-checking bench for gf_serial_mult (8x4, 8x8 and GF(2^4) instances).
`timescale 1ns/1ps
module tb_gf_serial_mult;
  import gf_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // WIDTH=8, COEFF_W=4
  logic       start_a = 1'b0;
  logic [7:0] in_a = '0;
  logic [3:0] coeff_a = '0;
  logic       acc_a = 1'b0;
  logic       busy_a, done_a;
  logic [7:0] result_a;

  // WIDTH=8, COEFF_W=8
  logic       start_b = 1'b0;
  logic [7:0] in_b = '0;
  logic [7:0] coeff_b = '0;
  logic       acc_b = 1'b0;
  logic       busy_b, done_b;
  logic [7:0] result_b;

  // WIDTH=4, COEFF_W=4, POLY=x^4+x+1
  logic       start_c = 1'b0;
  logic [3:0] in_c = '0;
  logic [3:0] coeff_c = '0;
  logic       acc_c = 1'b0;
  logic       busy_c, done_c;
  logic [3:0] result_c;

  gf_serial_mult #(.WIDTH(8), .COEFF_W(4), .POLY(AES_POLY)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .in(in_a), .coeff(coeff_a),
`ifdef GF_SERIAL_MULT_ACC_EN
    .acc(acc_a),
`endif
    .busy(busy_a), .result(result_a), .done(done_a)
  );

  gf_serial_mult #(.WIDTH(8), .COEFF_W(8), .POLY(AES_POLY)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .in(in_b), .coeff(coeff_b),
`ifdef GF_SERIAL_MULT_ACC_EN
    .acc(acc_b),
`endif
    .busy(busy_b), .result(result_b), .done(done_b)
  );

  gf_serial_mult #(.WIDTH(4), .COEFF_W(4), .POLY(GF16_POLY)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .in(in_c), .coeff(coeff_c),
`ifdef GF_SERIAL_MULT_ACC_EN
    .acc(acc_c),
`endif
    .busy(busy_c), .result(result_c), .done(done_c)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One operation on u_a; n counts edges from the accepting edge (inclusive) to
  // the edge after which done is seen high.
  task automatic op_a(input string tag, input logic [7:0] x, input logic [3:0] c,
                      input logic a, input logic [7:0] exp);
    int n;
    in_a = x; coeff_a = c; acc_a = a; start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    n = 1;
    chk({tag, "_busy"}, busy_a, 1);
    while (!done_a && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_lat"}, n, 5);
    chk({tag, "_res"}, result_a, exp);
    chk({tag, "_busy_at_done"}, busy_a, 0);
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, done_a, 0);
    chk({tag, "_hold"}, result_a, exp);
  endtask

  initial begin
    int n;
    int last;
    int ndone;
    int overlap;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_result", result_a, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    op_a("c9", 8'h57, 4'h9, 1'b0, 8'hD9);
    op_a("cB", 8'h57, 4'hB, 1'b0, 8'h77);
    op_a("cE", 8'h57, 4'hE, 1'b0, 8'h67);
    op_a("c0", 8'h57, 4'h0, 1'b0, 8'h00);
    op_a("cF", 8'h57, 4'hF, 1'b0, 8'h30);

    // Start pulses while busy must not disturb the in-flight operation.
    in_a = 8'h57; coeff_a = 4'h9; start_a = 1'b1;
    @(posedge clk); #1;
    n = 1;
    in_a = 8'hFF; coeff_a = 4'hF;
    @(posedge clk); #1; n++;
    @(posedge clk); #1; n++;
    start_a = 1'b0;
    while (!done_a && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("busy_ign_lat", n, 5);
    chk("busy_ign_res", result_a, 8'hD9);
    @(posedge clk); #1;

    // start held high: back-to-back operations every COEFF_W+1 cycles.
    in_a = 8'h57; coeff_a = 4'hE; start_a = 1'b1;
    n = 0; last = 0; ndone = 0; overlap = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      n++;
      if (busy_a && done_a) overlap++;
      if (done_a) begin
        ndone++;
        chk("b2b_period", n - last, 5);
        chk("b2b_res", result_a, 8'h67);
        last = n;
      end
    end
    start_a = 1'b0;
    chk("b2b_count", ndone, 3);
    chk("b2b_overlap", overlap, 0);
    repeat (6) @(posedge clk);
    #1;

    // Reset at the second RUN edge: no done pulse, result cleared.
    in_a = 8'h57; coeff_a = 4'hF; start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    @(posedge clk); #1;
    chk("mid_partial", result_a, 8'h57);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_busy", busy_a, 0);
    chk("mid_rst_result", result_a, 0);
    chk("mid_rst_done", done_a, 0);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (done_a) ndone++;
    end
    chk("mid_rst_no_done", ndone, 0);

    // FIPS-197 example on the 8-bit coefficient instance.
    in_b = 8'h57; coeff_b = 8'h13; start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    n = 1;
    while (!done_b && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    chk("w8_lat", n, 9);
    chk("w8_res", result_b, 8'hFE);

    // GF(2^4): 0x7 * 0x3 mod x^4+x+1.
    in_c = 4'h7; coeff_c = 4'h3; start_c = 1'b1;
    @(posedge clk); #1;
    start_c = 1'b0;
    n = 1;
    while (!done_c && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("gf16_lat", n, 5);
    chk("gf16_res", result_c, 4'h9);

`ifdef GF_SERIAL_MULT_ACC_EN
    op_a("acc0", 8'h57, 4'h9, 1'b0, 8'hD9);
    op_a("acc1", 8'h57, 4'hB, 1'b1, 8'hAE);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
